// File: rtl/kbd_cmd_pkg.sv
// Shared command codes, PS/2 set-2 scancodes and the scancode-to-command map
// for the keyboard command decoder.
package kbd_cmd_pkg;

   typedef enum logic [2:0] {
      CMD_NONE   = 3'd0,
      CMD_LEFT   = 3'd1,
      CMD_RIGHT  = 3'd2,
      CMD_THRUST = 3'd3,
      CMD_FIRE   = 3'd4,
      CMD_START  = 3'd5,
      CMD_PAUSE  = 3'd6
   } cmd_t;

   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_RIGHT = 8'h74;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_P     = 8'h4D;

   function automatic cmd_t decode_scancode(input logic [7:0] sc);
      case (sc)
         SC_LEFT,  SC_A: return CMD_LEFT;
         SC_RIGHT, SC_D: return CMD_RIGHT;
         SC_UP,    SC_W: return CMD_THRUST;
         SC_SPACE:       return CMD_FIRE;
         SC_ENTER:       return CMD_START;
         SC_P:           return CMD_PAUSE;
         default:        return CMD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/kbd_cmd_decoder_fifo.sv
// Small command FIFO for discrete game events; a pop on a full FIFO frees the
// slot for a push in the same cycle, a pop on an empty FIFO is ignored.
module cmd_fifo
   import kbd_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       push,
   input  logic                       pop,
   input  cmd_t                       din,
   output cmd_t                       dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   cmd_t          mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: storage has no reset; an entry is only ever read after it was written, and empty forces dout to NONE.
   always_ff @(posedge CLK) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout  = empty ? CMD_NONE : mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/kbd_cmd_decoder.sv
// Turns keyboard scancode events into Asteroid controls: hold timers for
// rotate/thrust, a rate-limited fire strobe and a FIFO for start/pause.
module kbd_cmd_decoder
   import kbd_cmd_pkg::*;
#(
   parameter int HOLD_CYCLES   = 25_000_000,
   parameter int FIRE_COOLDOWN = 5_000_000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] ScanCode,
   input  logic       valid_bit,
   output logic [2:0] cmd,
   output logic       cmd_valid,
   input  logic       cmd_pop,
   output logic       rot_left,
   output logic       rot_right,
   output logic       thrust,
   output logic       fire_pulse,
   output logic       overflow
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int CW = $clog2(FIRE_COOLDOWN + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic          s1, s2, s3;
   logic          evt;
   cmd_t          evt_cmd;
   logic [HW-1:0] left_cnt, right_cnt, thrust_cnt;
   logic [CW-1:0] cool_cnt;
   logic          fire_ok;
   logic          push_req;
   cmd_t          fifo_dout;
   logic          fifo_full, fifo_empty;
   logic [AW:0]   fifo_count;

   // valid_bit is asynchronous; ScanCode is stable long before s2 rises.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= valid_bit;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign evt      = s2 && !s3;
   assign evt_cmd  = evt ? decode_scancode(ScanCode) : CMD_NONE;
   assign fire_ok  = (evt_cmd == CMD_FIRE) && (cool_cnt == '0);
   assign push_req = (evt_cmd == CMD_START) || (evt_cmd == CMD_PAUSE);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         left_cnt   <= '0;
         right_cnt  <= '0;
         thrust_cnt <= '0;
      end else begin
         // NOTE: the saturating decrement is the default; the event case below overrides it because the last non-blocking assignment wins.
         left_cnt   <= (left_cnt   != '0) ? left_cnt   - HW'(1) : '0;
         right_cnt  <= (right_cnt  != '0) ? right_cnt  - HW'(1) : '0;
         thrust_cnt <= (thrust_cnt != '0) ? thrust_cnt - HW'(1) : '0;
         case (evt_cmd)
            CMD_LEFT: begin
               left_cnt  <= HW'(HOLD_CYCLES);
               right_cnt <= '0;
            end
            CMD_RIGHT: begin
               right_cnt <= HW'(HOLD_CYCLES);
               left_cnt  <= '0;
            end
            CMD_THRUST: thrust_cnt <= HW'(HOLD_CYCLES);
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cool_cnt   <= '0;
         fire_pulse <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         fire_pulse <= fire_ok;
         if (fire_ok)              cool_cnt <= CW'(FIRE_COOLDOWN);
         else if (cool_cnt != '0)  cool_cnt <= cool_cnt - CW'(1);
         // A push is lost only when full and no real pop frees a slot.
         if (push_req && fifo_full && !(cmd_pop && !fifo_empty)) overflow <= 1'b1;
      end
   end

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push_req),
      .pop   (cmd_pop),
      .din   (evt_cmd),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign cmd       = fifo_dout;
   assign cmd_valid = (fifo_count != '0);
   assign rot_left  = (left_cnt   != '0);
   assign rot_right = (right_cnt  != '0);
   assign thrust    = (thrust_cnt != '0);

endmodule

// File: tb/tb_kbd_cmd_decoder.sv
// Self-checking bench for kbd_cmd_decoder with short hold/cooldown timers and
// a queue scoreboard for the command FIFO.
module tb_kbd_cmd_decoder;

   localparam int HOLD  = 100;
   localparam int COOL  = 40;
   localparam int DEPTH = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] ScanCode = 8'h00;
   logic       valid_bit = 1'b0;
   logic       cmd_pop = 1'b0;
   logic [2:0] cmd;
   logic       cmd_valid, rot_left, rot_right, thrust, fire_pulse, overflow;

   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         overlap_cnt = 0;
   int         long_pulse = 0;
   logic       prev_fire = 1'b0;
   int         fire_times[$];
   logic [2:0] exp_q[$];
   logic       model_ovf = 1'b0;

   kbd_cmd_decoder #(
      .HOLD_CYCLES   (HOLD),
      .FIRE_COOLDOWN (COOL),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .ScanCode   (ScanCode),
      .valid_bit  (valid_bit),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .cmd_pop    (cmd_pop),
      .rot_left   (rot_left),
      .rot_right  (rot_right),
      .thrust     (thrust),
      .fire_pulse (fire_pulse),
      .overflow   (overflow)
   );

   initial forever #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (rot_left && rot_right) overlap_cnt <= overlap_cnt + 1;
      if (fire_pulse) fire_times.push_back(cyc);
      if (fire_pulse && prev_fire) long_pulse <= long_pulse + 1;
      prev_fire <= fire_pulse;
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic press(input logic [7:0] code);
      ScanCode  = code;
      valid_bit = 1'b1;
   endtask

   task automatic key_up();
      valid_bit = 1'b0;
   endtask

   task automatic stroke(input logic [7:0] code);
      press(code);
      tick(4);
      key_up();
      tick(4);
   endtask

   task automatic reset_dut();
      RST = 1'b0;
      tick(2);
      RST = 1'b1;
      tick(2);
      exp_q.delete();
      model_ovf = 1'b0;
   endtask

   task automatic push_cmd(input logic [7:0] code, input logic [2:0] exp_cmd);
      if (exp_q.size() < DEPTH) exp_q.push_back(exp_cmd);
      else model_ovf = 1'b1;
      stroke(code);
   endtask

   task automatic pop_check(input string tag);
      logic [2:0] exp_head;
      exp_head = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
      check({tag, "_valid"}, 32'(cmd_valid), 32'(1));
      check({tag, "_cmd"}, 32'(cmd), 32'(exp_head));
      cmd_pop = 1'b1;
      tick(1);
      cmd_pop = 1'b0;
   endtask

   initial begin
      int n;
      int hi;
      logic others;
      logic prev_left;
      int t0, t2;

      // Reset state
      RST = 1'b0;
      tick(3);
      check("rst_cmd", 32'(cmd), 32'(0));
      check("rst_cmd_valid", 32'(cmd_valid), 32'(0));
      check("rst_overflow", 32'(overflow), 32'(0));
      check("rst_holds", 32'({rot_left, rot_right, thrust, fire_pulse}), 32'(0));
      RST = 1'b1;
      tick(2);

      // Single LEFT: latency and exact hold length
      press(8'h6B);
      n = 0;
      while (!rot_left && n < 10) begin tick(1); n++; end
      check("t1_latency", 32'(n), 32'(3));
      key_up();
      hi = 0;
      others = 1'b0;
      while (rot_left && hi < 200) begin
         others |= rot_right | thrust | fire_pulse;
         tick(1);
         hi++;
      end
      check("t1_hold_len", 32'(hi), 32'(HOLD));
      check("t1_others", 32'(others), 32'(0));

      // LEFT then RIGHT 50 cycles later: handover in the same cycle
      tick(5);
      press(8'h1C);
      tick(4);
      key_up();
      tick(46);
      check("t2_left_before", 32'(rot_left), 32'(1));
      press(8'h74);
      n = 0;
      prev_left = rot_left;
      while (!rot_right && n < 10) begin
         prev_left = rot_left;
         tick(1);
         n++;
      end
      check("t2_right_rise", 32'(rot_right), 32'(1));
      check("t2_left_prev", 32'(prev_left), 32'(1));
      check("t2_left_drop", 32'(rot_left), 32'(0));
      key_up();
      tick(HOLD + 10);
      check("t2_no_overlap", 32'(overlap_cnt), 32'(0));
      check("t2_right_expired", 32'(rot_right), 32'(0));

      // FIRE cooldown: second dropped, third accepted
      fire_times.delete();
      t0 = cyc;
      press(8'h29); tick(4); key_up(); tick(6);
      press(8'h29); tick(4); key_up(); tick(36);
      t2 = cyc;
      press(8'h29); tick(4); key_up(); tick(6);
      check("t3_fire_count", 32'(fire_times.size()), 32'(2));
      if (fire_times.size() >= 2) begin
         check("t3_fire1_time", 32'(fire_times[0]), 32'(t0 + 3));
         check("t3_fire3_time", 32'(fire_times[1]), 32'(t2 + 3));
      end
      check("t3_pulse_width", 32'(long_pulse), 32'(0));

      // FIFO overflow after five STARTs with no pops
      reset_dut();
      for (int i = 0; i < 5; i++) begin
         push_cmd(8'h5A, 3'd5);
         check($sformatf("t4_ovf_%0d", i), 32'(overflow), 32'(model_ovf));
      end
      check("t4_valid", 32'(cmd_valid), 32'(1));
      check("t4_head", 32'(cmd), 32'(5));
      for (int i = 0; i < DEPTH; i++) pop_check($sformatf("t4_pop%0d", i));
      check("t4_empty_valid", 32'(cmd_valid), 32'(0));
      check("t4_empty_cmd", 32'(cmd), 32'(0));
      check("t4_ovf_sticky", 32'(overflow), 32'(1));

      // Full FIFO with pop and push in the same cycle
      reset_dut();
      push_cmd(8'h5A, 3'd5);
      push_cmd(8'h4D, 3'd6);
      push_cmd(8'h5A, 3'd5);
      push_cmd(8'h4D, 3'd6);
      press(8'h4D);
      tick(2);
      check("t5_head_at_pop", 32'(cmd), 32'(exp_q.pop_front()));
      exp_q.push_back(3'd6);
      cmd_pop = 1'b1;
      tick(1);
      cmd_pop = 1'b0;
      tick(3);
      key_up();
      tick(4);
      check("t5_ovf", 32'(overflow), 32'(0));
      for (int i = 0; i < DEPTH; i++) pop_check($sformatf("t5_pop%0d", i));
      check("t5_drained", 32'(cmd_valid), 32'(0));
      cmd_pop = 1'b1;
      tick(1);
      cmd_pop = 1'b0;
      check("t5_empty_pop", 32'(cmd_valid), 32'(0));
      push_cmd(8'h5A, 3'd5);
      pop_check("t5_after_empty_pop");
      check("t5_final_empty", 32'(cmd_valid), 32'(0));

      // Unknown code during thrust, then async reset mid-hold/cooldown
      reset_dut();
      push_cmd(8'h5A, 3'd5);
      stroke(8'h29);
      stroke(8'h75);
      check("t6_thrust_on", 32'(thrust), 32'(1));
      stroke(8'h12);
      check("t6_unknown_thrust", 32'(thrust), 32'(1));
      check("t6_unknown_rot", 32'({rot_left, rot_right}), 32'(0));
      check("t6_unknown_cmd", 32'({cmd_valid, cmd}), 32'({1'b1, 3'd5}));
      check("t6_unknown_ovf", 32'(overflow), 32'(0));
      #2 RST = 1'b0;
      #1;
      check("t6_rst_thrust", 32'(thrust), 32'(0));
      check("t6_rst_fifo", 32'({cmd_valid, cmd}), 32'(0));
      check("t6_rst_misc", 32'({rot_left, rot_right, fire_pulse, overflow}), 32'(0));
      tick(2);
      RST = 1'b1;
      exp_q.delete();
      model_ovf = 1'b0;
      tick(2);
      fire_times.delete();
      t0 = cyc;
      stroke(8'h29);
      check("t6_fire_after_rst", 32'(fire_times.size()), 32'(1));
      if (fire_times.size() >= 1)
         check("t6_fire_time", 32'(fire_times[0]), 32'(t0 + 3));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
